corner_clause_loader: RTL and testbench
=======================================

CORNER_CLAUSE_LOADER -- requirements
Module: corner_clause_loader

Interface
REQ-001 Parameter MAXIMUM_BIT_WIDTH_OF_COEFFICIENT, default 4, is the bit width C of one coefficient.
REQ-002 Parameter MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX, default 1, is V; the block handles 2**V variables plus one bias term.
REQ-003 Parameter MAX_BIT_WIDTH_OF_INTEGER_VARIABLE, default 4, is the width of the variable-index word.
REQ-004 Parameter MAX_BIT_WIDTH_OF_CLAUSES_INDEX, default 2, is K; the block handles up to 2**K clauses.
REQ-005 The design SHALL use one clock; reset is synchronous and active-high; the ports are in_clk and in_reset.
REQ-006 in_clk  input  1  is the single rising-edge clock.
REQ-007 in_reset  input  1  is the synchronous, active-high reset.
REQ-008 in_start  input  1  is a one-cycle request to load a formula.
REQ-009 in_num_clauses  input  K+1  is the number of clauses to load.
REQ-010 in_variable_index  input  MAX_BIT_WIDTH_OF_INTEGER_VARIABLE  is the variable to hold unchanged; it is latched when the load starts.
REQ-011 out_mem_read  output  1  is the read strobe to the clause memory.
REQ-012 out_mem_addr  output  K  is the clause memory address.
REQ-013 in_mem_valid  input  1  marks that read data is valid.
REQ-014 in_mem_data  input  (2**V+1)*C  carries the clause coefficients, with the bias in the top C bits.
REQ-015 out_clause_coefficients_integer  output  (2**V+1)*C  carries the coefficients to the corner proposer.
REQ-016 out_clause_index  output  K  is the clause slot being written.
REQ-017 out_clause_write  output  1  is the write strobe for the clause slot.
REQ-018 out_variable_to_be_unchanced_index  output  MAX_BIT_WIDTH_OF_INTEGER_VARIABLE  is the latched variable index.
REQ-019 out_reduce_enable  output  2**K  is the per-clause enable mask.
REQ-020 out_busy  output  1  is high while a load is in progress.
REQ-021 out_done  output  1  is a one-cycle pulse when the load completes.

Function
REQ-022 The FSM SHALL have the states IDLE, FETCH, WAIT, WRITE and DONE.
REQ-023 IDLE: on in_start=1, the FSM SHALL latch in_variable_index, latch N=min(in_num_clauses, 2**K), clear the clause counter, clear out_reduce_enable, and then enter FETCH, or enter DONE if N=0.
REQ-024 in_start SHALL be ignored in every state except IDLE.
REQ-025 FETCH: out_mem_read=1 for exactly this one cycle, with out_mem_addr=counter; the FSM then enters WAIT.
REQ-026 WAIT: the FSM SHALL stay until in_mem_valid=1, capture in_mem_data into out_clause_coefficients_integer on that edge, and then enter WRITE.
REQ-027 in_mem_valid outside WAIT SHALL be ignored, with no capture.
REQ-028 There SHALL be no timeout in WAIT.
REQ-029 WRITE: out_clause_write=1 for one cycle, with out_clause_index=counter and the coefficients stable; the FSM SHALL set bit [counter] of an internal mask.
REQ-030 From WRITE, if counter=N-1 the FSM SHALL enter DONE; otherwise it SHALL increment the counter and enter FETCH.
REQ-031 The counter SHALL never wrap.
REQ-032 DONE: out_done=1 for one cycle and out_reduce_enable=internal mask; the FSM then returns to IDLE.
REQ-033 out_reduce_enable SHALL be held until the next accepted in_start or reset.
REQ-034 out_reduce_enable SHALL read all-zero throughout a load and change only on entry to DONE.
REQ-035 out_busy SHALL be 1 in FETCH, WAIT and WRITE, and 0 in IDLE and DONE.
REQ-036 out_clause_coefficients_integer, out_clause_index and out_variable_to_be_unchanced_index SHALL hold their last values between writes.
REQ-037 Latency: with in_mem_valid arriving one cycle after the read, out_done SHALL assert 3N+1 cycles after the in_start edge.
REQ-038 Each extra valid-wait cycle SHALL add exactly one cycle to that latency.
REQ-039 N=0 SHALL produce out_done one cycle after in_start, with mask 0 and no reads or writes.
REQ-040 in_num_clauses>2**K SHALL be clamped to 2**K.
REQ-041 Mask bits above N-1 SHALL be 0.
REQ-042 All outputs SHALL be registered.

Reset
REQ-043 When in_reset=1 at a clock edge, the FSM SHALL enter IDLE and all outputs and internal registers SHALL be cleared to 0, in any state including mid-load.
REQ-044 Reset SHALL take priority over in_start in the same cycle.
REQ-045 After a mid-load reset, no out_clause_write or out_done SHALL occur until a new in_start.

Verification
REQ-046 Memory holds 12'h111, 12'h121, 12'h131, 12'h141, with valid one cycle after the read; in_num_clauses=4, in_variable_index=0 -> four writes at indices 0..3 with those values in order, then out_reduce_enable=4'b1111 and out_done at cycle 13.
REQ-047 Same stimulus with in_num_clauses=2 -> writes 12'h111 and 12'h121 only, out_reduce_enable=4'b0011, out_done at cycle 7.
REQ-048 in_num_clauses=0 -> no out_mem_read, out_reduce_enable=0, out_done one cycle after start.
REQ-049 in_num_clauses=7 -> clamped to 4; result is identical to REQ-046.
REQ-050 Valid delayed 3 cycles on clause 1 plus a spurious valid during FETCH -> total latency 15 cycles, data unaffected, and in_start pulsed during the load is ignored.
REQ-051 in_reset asserted in WAIT of clause 2 -> next cycle all outputs are 0 and the FSM is in IDLE; a later in_start reloads correctly from clause 0.

Source files
------------

// File: rtl/corner_clause_loader.sv
// Fetches up to 2**K clause coefficient words from an external memory, writes each
// one into its clause slot, and reports which slots were loaded through a held mask.
module corner_clause_loader #(
  parameter int MAXIMUM_BIT_WIDTH_OF_COEFFICIENT    = 4,
  parameter int MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX = 1,
  parameter int MAX_BIT_WIDTH_OF_INTEGER_VARIABLE   = 4,
  parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX      = 2
) (
  input  logic                                        in_clk,
  input  logic                                        in_reset,
  input  logic                                        in_start,
  input  logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0]     in_num_clauses,
  input  logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] in_variable_index,
  output logic                                        out_mem_read,
  output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]   out_mem_addr,
  input  logic                                        in_mem_valid,
  input  logic [(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] in_mem_data,
  output logic [(2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX+1)*MAXIMUM_BIT_WIDTH_OF_COEFFICIENT-1:0] out_clause_coefficients_integer,
  output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0]   out_clause_index,
  output logic                                        out_clause_write,
  output logic [MAX_BIT_WIDTH_OF_INTEGER_VARIABLE-1:0] out_variable_to_be_unchanced_index,
  output logic [2**MAX_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_reduce_enable,
  output logic                                        out_busy,
  output logic                                        out_done
);

  localparam int K   = MAX_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int NCL = 2**K;
  localparam int IW  = MAX_BIT_WIDTH_OF_INTEGER_VARIABLE;
  localparam int DW  = (2**MAXIMUM_BIT_WIDTH_OF_VARIABLE_INDEX + 1) * MAXIMUM_BIT_WIDTH_OF_COEFFICIENT;
  localparam logic [K:0] MAX_N = (K+1)'(NCL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [K-1:0]     cnt_q, cnt_d;
  logic [K:0]       n_q, n_d;
  logic [NCL-1:0]   mask_q, mask_d;
  logic [IW-1:0]    var_q, var_d;
  logic [DW-1:0]    coef_q, coef_d;
  logic [K-1:0]     addr_q, addr_d;
  logic [K-1:0]     cidx_q, cidx_d;
  logic [NCL-1:0]   enable_q, enable_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [K:0]       n_clamped;
  logic [K:0]       cnt_plus1;
  logic             last_clause;

  assign n_clamped   = (in_num_clauses > MAX_N) ? MAX_N : in_num_clauses;
  assign cnt_plus1   = {1'b0, cnt_q} + {{K{1'b0}}, 1'b1};
  assign last_clause = (cnt_plus1 == n_q);

  // NOTE: every register, including the FSM state, is cleared by the synchronous
  // reset so a mid-load reset leaves no stale strobe or mask behind.
  always_ff @(posedge in_clk) begin
    if (in_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      mask_q   <= '0;
      var_q    <= '0;
      coef_q   <= '0;
      addr_q   <= '0;
      cidx_q   <= '0;
      enable_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      mask_q   <= mask_d;
      var_q    <= var_d;
      coef_q   <= coef_d;
      addr_q   <= addr_d;
      cidx_q   <= cidx_d;
      enable_q <= enable_d;
      read_q   <= read_d;
      write_q  <= write_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_start) state_d = (n_clamped == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  if (in_mem_valid) state_d = S_WRITE;
      S_WRITE: state_d = last_clause ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the registered outputs line up with the state.
  always_comb begin
    cnt_d    = cnt_q;
    n_d      = n_q;
    mask_d   = mask_q;
    var_d    = var_q;
    coef_d   = coef_q;
    addr_d   = addr_q;
    cidx_d   = cidx_q;
    enable_d = enable_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          var_d    = in_variable_index;
          n_d      = n_clamped;
          cnt_d    = '0;
          mask_d   = '0;
          enable_d = '0;
        end
      end
      S_WAIT: if (in_mem_valid) coef_d = in_mem_data;
      S_WRITE: begin
        mask_d[cnt_q] = 1'b1;
        if (!last_clause) cnt_d = cnt_plus1[K-1:0];
      end
      default: ;
    endcase
    read_d  = (state_d == S_FETCH);
    write_d = (state_d == S_WRITE);
    busy_d  = read_d | write_d | (state_d == S_WAIT);
    done_d  = (state_d == S_DONE);
    if (read_d)  addr_d   = cnt_d;
    if (write_d) cidx_d   = cnt_d;
    if (done_d)  enable_d = mask_d;
  end

  assign out_mem_read                       = read_q;
  assign out_mem_addr                       = addr_q;
  assign out_clause_coefficients_integer    = coef_q;
  assign out_clause_index                   = cidx_q;
  assign out_clause_write                   = write_q;
  assign out_variable_to_be_unchanced_index = var_q;
  assign out_reduce_enable                  = enable_q;
  assign out_busy                           = busy_q;
  assign out_done                           = done_q;

endmodule

// File: tb/tb_corner_clause_loader.sv
// Directed bench for corner_clause_loader: a memory responder with per-address
// valid delay, and a scoreboard of expected clause writes popped on each write strobe.
module tb_corner_clause_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  num;
  logic [3:0]  vidx;
  logic        mem_read;
  logic [1:0]  mem_addr;
  logic        mem_valid = 1'b0;
  logic [11:0] mem_data  = '0;
  logic [11:0] coef;
  logic [1:0]  cidx;
  logic        cwrite;
  logic [3:0]  var_o;
  logic [3:0]  enable;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [11:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [11:0] mem [4];
  int          delay_cfg [4];
  bit          spur_cfg;
  int          pend;
  logic [1:0]  pend_addr;
  int          reads;

  corner_clause_loader dut (
    .in_clk                             (clk),
    .in_reset                           (rst),
    .in_start                           (start),
    .in_num_clauses                     (num),
    .in_variable_index                  (vidx),
    .out_mem_read                       (mem_read),
    .out_mem_addr                       (mem_addr),
    .in_mem_valid                       (mem_valid),
    .in_mem_data                        (mem_data),
    .out_clause_coefficients_integer    (coef),
    .out_clause_index                   (cidx),
    .out_clause_write                   (cwrite),
    .out_variable_to_be_unchanced_index (var_o),
    .out_reduce_enable                  (enable),
    .out_busy                           (busy),
    .out_done                           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Memory model: valid arrives delay_cfg[addr] cycles after the read cycle.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (mem_read) begin
      check("read_addr_order", {30'd0, mem_addr}, reads);
      reads++;
      pend      = delay_cfg[mem_addr];
      pend_addr = mem_addr;
      if (spur_cfg) begin
        mem_valid = 1'b1;
        mem_data  = 12'hBAD;
      end
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_valid = 1'b1;
        mem_data  = mem[pend_addr];
      end
    end
  end

  // Scoreboard consumer for clause writes, plus the mask-stays-zero-while-busy rule.
  always @(negedge clk) begin
    wr_t e;
    if (busy) check("enable_zero_during_load", {28'd0, enable}, 32'd0);
    if (cwrite) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, cwrite}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_index", {30'd0, cidx}, {30'd0, e.idx});
        check("write_data", {20'd0, coef}, {20'd0, e.data});
      end
    end
  end

  task automatic push_writes(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(wr_t'{idx: 2'(i), data: mem[i]});
  endtask

  task automatic run_load(input logic [2:0] n, input logic [3:0] v, input int exp_cycles,
                          input logic [3:0] exp_mask, input int exp_reads, input bit mid_start);
    int cyc;
    @(negedge clk);
    reads = 0;
    start = 1'b1;
    num   = n;
    vidx  = v;
    @(negedge clk);
    start = 1'b0;
    vidx  = ~v;
    cyc   = 1;
    while (!done && cyc < 200) begin
      start = mid_start && (cyc == 4);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_latency", cyc, exp_cycles);
    check("reduce_enable", {28'd0, enable}, {28'd0, exp_mask});
    check("busy_low_in_done", {31'd0, busy}, 32'd0);
    check("latched_var_index", {28'd0, var_o}, {28'd0, v});
    check("read_count", reads, exp_reads);
    check("scoreboard_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("reduce_enable_held", {28'd0, enable}, {28'd0, exp_mask});
  endtask

  initial begin
    int seen;
    bit found;
    mem[0] = 12'h111;
    mem[1] = 12'h121;
    mem[2] = 12'h131;
    mem[3] = 12'h141;
    for (int i = 0; i < 4; i++) delay_cfg[i] = 1;
    spur_cfg = 1'b0;
    pend     = 0;
    reads    = 0;
    rst   = 1'b1;
    start = 1'b0;
    num   = '0;
    vidx  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_outputs", {mem_read, mem_addr, coef, cidx, cwrite, var_o, enable, busy, done}, 32'd0);

    // Full load of four clauses
    push_writes(4);
    run_load(3'd4, 4'd0, 13, 4'b1111, 4, 1'b0);

    // Partial load, upper mask bits stay clear
    push_writes(2);
    run_load(3'd2, 4'd3, 7, 4'b0011, 2, 1'b0);

    // Empty load: no traffic, coefficients keep their last value
    run_load(3'd0, 4'd2, 1, 4'b0000, 0, 1'b0);
    check("coef_held_after_empty", {20'd0, coef}, 32'h121);
    check("index_held_after_empty", {30'd0, cidx}, 32'd1);

    // Oversized count clamps to four
    push_writes(4);
    run_load(3'd7, 4'd1, 13, 4'b1111, 4, 1'b0);

    // Slow valid on clause 1, spurious valid during FETCH, ignored start mid-load
    delay_cfg[1] = 3;
    spur_cfg     = 1'b1;
    push_writes(4);
    run_load(3'd4, 4'd6, 15, 4'b1111, 4, 1'b1);
    delay_cfg[1] = 1;
    spur_cfg     = 1'b0;

    // Reset during WAIT of clause 2
    push_writes(2);
    @(negedge clk);
    reads = 0;
    start = 1'b1;
    num   = 3'd4;
    vidx  = 4'd5;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (mem_read && mem_addr == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_clause2_fetch", {31'd0, found}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_load_reset_outputs", {mem_read, mem_addr, coef, cidx, cwrite, var_o, enable, busy, done}, 32'd0);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (cwrite || done || busy) seen++;
    end
    check("quiet_after_reset", seen, 0);
    check("scoreboard_after_reset", exp_q.size(), 0);

    push_writes(4);
    run_load(3'd4, 4'd9, 13, 4'b1111, 4, 1'b0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    start = 1'b1;
    num   = 3'd4;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check("reset_beats_start_busy", {31'd0, busy}, 32'd0);
    check("reset_beats_start_enable", {28'd0, enable}, 32'd0);
    @(negedge clk);
    check("reset_beats_start_no_read", {31'd0, mem_read}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
